// File: rtl/player_motion.sv
`default_nettype none
// ============================================================================
// Module   : player_motion
// Purpose  : Per-frame player horizontal motion and jump/fall/land FSM,
//            paired with the scrolling terrain block; drives sprite hit.
// Revision : 1.0
// ============================================================================
module player_motion #(
    parameter logic [9:0]  SIZE     = 10'd15,
    parameter logic [9:0]  SPEED    = 10'd6,
    parameter logic [9:0]  JUMP_V   = 10'd12,
    parameter logic [9:0]  GRAV     = 10'd1,
    parameter logic [9:0]  MAX_FALL = 10'd8,
    parameter logic [9:0]  X_MIN    = 10'd0,
    parameter logic [9:0]  X_MAX    = 10'd639,
    parameter logic [9:0]  Y_MAX    = 10'd479,
    parameter logic [13:0] MAP_LEN  = 14'd4479
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic [9:0]  start_X,
    input  logic [9:0]  start_Y,
    input  logic        can_move,
    input  logic [13:0] top,
    input  logic [13:0] top_left,
    input  logic [13:0] top_right,
    input  logic [13:0] bot,
    input  logic [13:0] excess,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [13:0] player_location,
    output logic        is_move,
    output logic [13:0] excess_is_move,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        is_player
);

    typedef enum logic [1:0] {
        ST_GROUND  = 2'd0,
        ST_RISE    = 2'd1,
        ST_FALL    = 2'd2,
        ST_RESPAWN = 2'd3
    } state_t;

    localparam logic [7:0] c_KEY_LEFT  = 8'h04;
    localparam logic [7:0] c_KEY_RIGHT = 8'h07;
    localparam logic [7:0] c_KEY_JUMP  = 8'h1A;

    // 12-bit signed intermediates leave headroom so no sum can wrap
    localparam logic signed [11:0] c_SIZE     = $signed({2'b00, SIZE});
    localparam logic signed [11:0] c_X_LO     = $signed({2'b00, X_MIN}) + c_SIZE;
    localparam logic signed [11:0] c_X_HI     = $signed({2'b00, X_MAX}) - c_SIZE;
    localparam logic signed [11:0] c_Y_MAX    = $signed({2'b00, Y_MAX});
    localparam logic signed [11:0] c_JUMP     = $signed({2'b00, JUMP_V});
    localparam logic signed [11:0] c_GRAV     = $signed({2'b00, GRAV});
    localparam logic signed [11:0] c_MAX_FALL = $signed({2'b00, MAX_FALL});
    localparam logic [13:0]        c_LOC_MIN  = {4'b0000, SIZE};
    localparam logic [13:0]        c_LOC_MAX  = MAP_LEN - {4'b0000, SIZE};
    localparam logic [13:0]        c_STEP     = {4'b0000, SPEED};

    logic               r_frame_d;
    logic               r_tick;
    logic signed [11:0] r_vy;
    state_t             r_state;

    logic signed [11:0] w_px, w_py, w_feet, w_head;
    logic signed [11:0] w_top, w_bot, w_top_l, w_top_r;
    logic               w_key_r, w_key_l, w_key_jump;
    logic               w_h_go, w_scr_move;
    logic [13:0]        w_loc_new, w_delta;
    logic signed [11:0] w_step, w_sx_raw, w_sx;
    logic signed [11:0] w_ny_rise, w_vy_dec, w_vy_inc, w_vy_fall, w_ny_fall;
    logic signed [11:0] w_dx, w_dy, w_adx, w_ady;
    logic               w_unused;

    assign w_px    = $signed({2'b00, pos_x});
    assign w_py    = $signed({2'b00, pos_y});
    assign w_feet  = w_py + c_SIZE;
    assign w_head  = w_py - c_SIZE;
    assign w_top   = $signed({2'b00, top[9:0]});
    assign w_bot   = $signed({2'b00, bot[9:0]});
    assign w_top_l = $signed({2'b00, top_left[9:0]});
    assign w_top_r = $signed({2'b00, top_right[9:0]});

    assign w_key_r    = (keycode == c_KEY_RIGHT);
    assign w_key_l    = (keycode == c_KEY_LEFT);
    assign w_key_jump = (keycode == c_KEY_JUMP);
    assign w_h_go     = (w_key_r && !(w_top_r < w_feet)) || (w_key_l && !(w_top_l < w_feet));
    assign w_scr_move = can_move || (excess != 14'd0);

    always_comb begin
        w_loc_new = player_location;
        if (w_key_r)
            w_loc_new = (player_location > c_LOC_MAX - c_STEP) ? c_LOC_MAX : player_location + c_STEP;
        else if (w_key_l)
            w_loc_new = (player_location < c_LOC_MIN + c_STEP) ? c_LOC_MIN : player_location - c_STEP;
        w_delta = (w_loc_new >= player_location) ? w_loc_new - player_location
                                                 : player_location - w_loc_new;
    end

    // On-screen motion follows the map step, or the scroll residual when terrain clamps
    assign w_step   = can_move ? $signed({2'b00, w_delta[9:0]}) : $signed({2'b00, excess[9:0]});
    assign w_sx_raw = w_key_r ? w_px + w_step : w_px - w_step;
    assign w_sx     = (w_sx_raw < c_X_LO) ? c_X_LO : (w_sx_raw > c_X_HI) ? c_X_HI : w_sx_raw;

    assign w_ny_rise = w_py - r_vy;
    assign w_vy_dec  = r_vy - c_GRAV;
    assign w_vy_inc  = r_vy + c_GRAV;
    assign w_vy_fall = (w_vy_inc > c_MAX_FALL) ? c_MAX_FALL : w_vy_inc;
    assign w_ny_fall = w_py + w_vy_fall;

    always_ff @(posedge Clk) begin
        r_frame_d <= frame_clk;
        if (Reset) begin
            r_tick          <= 1'b0;
            pos_x           <= start_X;
            pos_y           <= start_Y;
            player_location <= {4'b0000, start_X};
            is_move         <= 1'b0;
            excess_is_move  <= 14'd0;
            r_vy            <= 12'sd0;
            r_state         <= ST_GROUND;
        end else begin
            r_tick <= frame_clk & ~r_frame_d;
            if (r_tick) begin
                if (r_state == ST_RESPAWN) begin
                    pos_x           <= start_X;
                    pos_y           <= start_Y;
                    player_location <= {4'b0000, start_X};
                    is_move         <= 1'b0;
                    excess_is_move  <= 14'd0;
                    r_vy            <= 12'sd0;
                    r_state         <= ST_GROUND;
                end else begin
                    if (w_h_go) begin
                        player_location <= w_loc_new;
                        excess_is_move  <= w_delta;
                        is_move         <= w_scr_move;
                        if (w_scr_move)
                            pos_x <= w_sx[9:0];
                    end else begin
                        is_move        <= 1'b0;
                        excess_is_move <= 14'd0;
                    end

                    case (r_state)
                        ST_GROUND: begin
                            if (w_key_jump) begin
                                r_vy    <= c_JUMP;
                                r_state <= ST_RISE;
                            end else if (w_feet < w_top) begin
                                r_vy    <= 12'sd0;
                                r_state <= ST_FALL;
                            end
                        end
                        ST_RISE: begin
                            if ((w_head > w_bot) && (w_ny_rise - c_SIZE <= w_bot)) begin
                                pos_y   <= 10'(w_bot + c_SIZE + 12'sd1);
                                r_vy    <= 12'sd0;
                                r_state <= ST_FALL;
                            end else if (w_ny_rise < c_SIZE) begin
                                pos_y   <= SIZE;
                                r_vy    <= 12'sd0;
                                r_state <= ST_FALL;
                            end else begin
                                pos_y <= w_ny_rise[9:0];
                                r_vy  <= w_vy_dec;
                                if (w_vy_dec <= 12'sd0)
                                    r_state <= ST_FALL;
                            end
                        end
                        ST_FALL: begin
                            if ((w_feet <= w_top) && (w_ny_fall + c_SIZE >= w_top)) begin
                                pos_y   <= 10'(w_top - c_SIZE);
                                r_vy    <= 12'sd0;
                                r_state <= ST_GROUND;
                            end else begin
                                pos_y <= w_ny_fall[9:0];
                                r_vy  <= w_vy_fall;
                                if (w_ny_fall + c_SIZE > c_Y_MAX)
                                    r_state <= ST_RESPAWN;
                            end
                        end
                        default: r_state <= ST_GROUND;
                    endcase
                end
            end
        end
    end

    assign w_dx      = $signed({2'b00, DrawX}) - w_px;
    assign w_dy      = $signed({2'b00, DrawY}) - w_py;
    assign w_adx     = (w_dx < 12'sd0) ? -w_dx : w_dx;
    assign w_ady     = (w_dy < 12'sd0) ? -w_dy : w_dy;
    assign is_player = (w_adx <= c_SIZE) && (w_ady <= c_SIZE);

    assign w_unused = ^{top[13:10], bot[13:10], top_left[13:10], top_right[13:10], w_sx[11:10]};

endmodule
`default_nettype wire

// File: tb/tb_player_motion.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_motion
// Purpose  : Directed vector table plus hand sequences for player_motion.
// Revision : 1.0
// ============================================================================
module tb_player_motion;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_N = 8'h00;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [7:0]  keycode = 8'h00;
    logic [9:0]  start_X = 10'd100;
    logic [9:0]  start_Y = 10'd300;
    logic        can_move = 1'b1;
    logic [13:0] top = 14'd315;
    logic [13:0] top_left = 14'd315;
    logic [13:0] top_right = 14'd315;
    logic [13:0] bot = 14'd0;
    logic [13:0] excess = 14'd0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic [13:0] player_location;
    logic        is_move;
    logic [13:0] excess_is_move;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        is_player;

    int total = 0;
    int bad = 0;

    always #5 Clk = ~Clk;

    player_motion dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_clk      (frame_clk),
        .keycode        (keycode),
        .start_X        (start_X),
        .start_Y        (start_Y),
        .can_move       (can_move),
        .top            (top),
        .top_left       (top_left),
        .top_right      (top_right),
        .bot            (bot),
        .excess         (excess),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .player_location(player_location),
        .is_move        (is_move),
        .excess_is_move (excess_is_move),
        .pos_x          (pos_x),
        .pos_y          (pos_y),
        .is_player      (is_player)
    );

    typedef struct {
        logic [7:0] key;
        logic       cm;
        int         tl;
        int         tr;
        int         exc;
        int         frames;
        int         ex_x;
        int         ex_y;
        int         ex_loc;
        int         ex_mv;
        int         ex_exc;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int x, input int y, input int loc,
                           input int mv, input int exc);
        chk({tag, ".pos_x"}, int'(pos_x), x);
        chk({tag, ".pos_y"}, int'(pos_y), y);
        chk({tag, ".location"}, int'(player_location), loc);
        chk({tag, ".is_move"}, int'(is_move), mv);
        chk({tag, ".excess_is_move"}, int'(excess_is_move), exc);
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge Clk) frame_clk = 1'b1;
            @(negedge Clk);
            @(negedge Clk) frame_clk = 1'b0;
            @(negedge Clk);
        end
    endtask

    task automatic do_reset(input int sx, input int sy);
        @(negedge Clk);
        start_X   = 10'(sx);
        start_Y   = 10'(sy);
        frame_clk = 1'b0;
        Reset     = 1'b1;
        @(negedge Clk);
        @(negedge Clk) Reset = 1'b0;
    endtask

    task automatic set_tops(input int t);
        top       = 14'(t);
        top_left  = 14'(t);
        top_right = 14'(t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           key    cm   tl   tr  exc frm    x    y   loc mv exc
        vecs[0]  = '{KEY_D, 1'b1, 315, 315,   0,   3, 118, 300,  118, 1, 6};
        vecs[1]  = '{KEY_A, 1'b1, 315, 315,   0,   1, 112, 300,  112, 1, 6};
        vecs[2]  = '{KEY_D, 1'b0, 315, 315,   0,   2, 112, 300,  124, 0, 6};
        vecs[3]  = '{KEY_D, 1'b0, 315, 315,   4,   1, 116, 300,  130, 1, 6};
        vecs[4]  = '{KEY_A, 1'b0, 315, 315,   3,   1, 113, 300,  124, 1, 6};
        vecs[5]  = '{KEY_N, 1'b1, 315, 315,   0,   1, 113, 300,  124, 0, 0};
        vecs[6]  = '{KEY_D, 1'b1, 315, 300,   0,   1, 113, 300,  124, 0, 0};
        vecs[7]  = '{KEY_A, 1'b1, 315, 300,   0,   1, 107, 300,  118, 1, 6};
        vecs[8]  = '{KEY_A, 1'b1, 300, 315,   0,   1, 107, 300,  118, 0, 0};
        vecs[9]  = '{KEY_A, 1'b1, 315, 315,   0,  16,  15, 300,   22, 1, 6};
        vecs[10] = '{KEY_A, 1'b1, 315, 315,   0,   1,  15, 300,   16, 1, 6};
        vecs[11] = '{KEY_A, 1'b1, 315, 315,   0,   1,  15, 300,   15, 1, 1};
        vecs[12] = '{KEY_A, 1'b1, 315, 315,   0,   1,  15, 300,   15, 1, 0};
        vecs[13] = '{KEY_D, 1'b0, 315, 315,   0, 742,  15, 300, 4464, 0, 3};
        vecs[14] = '{KEY_D, 1'b0, 315, 315,   0,   1,  15, 300, 4464, 0, 0};
        vecs[15] = '{KEY_D, 1'b0, 315, 315, 700,   1, 624, 300, 4464, 1, 0};

        // Reset state and horizontal table
        set_tops(315);
        do_reset(100, 300);
        chk_all("reset", 100, 300, 100, 0, 0);

        for (int i = 0; i < 16; i++) begin
            keycode   = vecs[i].key;
            can_move  = vecs[i].cm;
            top       = 14'd315;
            top_left  = 14'(vecs[i].tl);
            top_right = 14'(vecs[i].tr);
            excess    = 14'(vecs[i].exc);
            frames(vecs[i].frames);
            chk_all($sformatf("vec%0d", i), vecs[i].ex_x, vecs[i].ex_y, vecs[i].ex_loc,
                    vecs[i].ex_mv, vecs[i].ex_exc);
        end

        // Jump arc and landing
        keycode  = KEY_N;
        can_move = 1'b1;
        excess   = 14'd0;
        bot      = 14'd0;
        set_tops(350);
        do_reset(200, 335);
        chk_all("jreset", 200, 335, 200, 0, 0);
        keycode = KEY_D;
        repeat (10) @(negedge Clk);
        chk("hold_no_tick.pos_x", int'(pos_x), 200);
        chk("hold_no_tick.location", int'(player_location), 200);
        keycode = KEY_W;
        frames(1);
        chk("jump_start.pos_y", int'(pos_y), 335);
        chk("jump_start.is_move", int'(is_move), 0);
        keycode = KEY_N;
        frames(1);
        chk("rise1.pos_y", int'(pos_y), 323);
        frames(11);
        chk("apex.pos_y", int'(pos_y), 257);
        frames(8);
        chk("fall8.pos_y", int'(pos_y), 293);
        frames(5);
        chk("fall13.pos_y", int'(pos_y), 333);
        frames(1);
        chk("land.pos_y", int'(pos_y), 335);
        frames(1);
        chk("ground_hold.pos_y", int'(pos_y), 335);

        // Head bump against a ceiling at 300
        bot = 14'd300;
        keycode = KEY_W;
        frames(1);
        keycode = KEY_N;
        frames(2);
        chk("bump.pos_y", int'(pos_y), 316);
        frames(6);
        chk("bump_land.pos_y", int'(pos_y), 335);

        // Fall off the screen bottom and respawn
        bot = 14'd0;
        set_tops(1023);
        do_reset(100, 300);
        frames(9);
        chk("drop9.pos_y", int'(pos_y), 336);
        frames(16);
        chk("drop25.pos_y", int'(pos_y), 464);
        frames(1);
        chk("drop26.pos_y", int'(pos_y), 472);
        start_X = 10'd60;
        start_Y = 10'd250;
        set_tops(265);
        keycode = KEY_D;
        frames(1);
        chk_all("respawn", 60, 250, 60, 0, 0);
        keycode = KEY_N;
        frames(1);
        chk("respawn_ground.pos_y", int'(pos_y), 250);

        // Reset in the middle of a jump
        set_tops(315);
        do_reset(100, 300);
        keycode = KEY_W;
        frames(1);
        keycode = KEY_N;
        frames(2);
        chk("midrise.pos_y", int'(pos_y), 277);
        @(negedge Clk) Reset = 1'b1;
        @(negedge Clk);
        chk_all("midrise_reset", 100, 300, 100, 0, 0);
        Reset = 1'b0;
        frames(1);
        chk("after_reset.pos_y", int'(pos_y), 300);

        // Sprite hit window at (100,300)
        DrawX = 10'd115; DrawY = 10'd300; #1;
        chk("hit.edge_right", int'(is_player), 1);
        DrawX = 10'd116; DrawY = 10'd300; #1;
        chk("hit.out_right", int'(is_player), 0);
        DrawX = 10'd85;  DrawY = 10'd285; #1;
        chk("hit.corner", int'(is_player), 1);
        DrawX = 10'd85;  DrawY = 10'd284; #1;
        chk("hit.out_top", int'(is_player), 0);
        DrawX = 10'd100; DrawY = 10'd316; #1;
        chk("hit.out_bottom", int'(is_player), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
